// File: rtl/wb_arbiter.sv
// Two-master, one-slave Wishbone classic arbiter with a bus-timeout watchdog.
// Master 0 is the cpu, master 1 the DMA/debug port. A grant is registered
// and held for the whole of the owner's cyc; an IDLE cycle always separates
// two owners. A stalled slave is cut off with a forced err so that no master
// can hang the shared bus.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no owner, slave side driven to 0, arbitration on cyc_i
// OWN0  | master 0 (cpu) owns the bus until m0_cyc_i drops
// OWN1  | master 1 (DMA/debug) owns the bus until m1_cyc_i drops

module wb_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic        m0_rty_o,

  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        m1_rty_o,

  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  input  logic        s_rty_i,

  output logic [1:0]  grant_o,
  output logic        bus_timeout_o
);

  // Counter must hold the value TIMEOUT_CYCLES itself; keep at least one bit
  // so the watchdog-off build still elaborates.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TC_LIMIT = CW'(TIMEOUT_CYCLES);
  localparam bit WD_ON = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t        state;
  logic          last_owner;
  logic [1:0]    grant_q;
  logic [CW-1:0] stall_cnt;

  logic own0;
  logic own1;
  logic wd_fire;
  logic stalled;

  // While reset is held the whole bus goes quiet immediately, not one edge
  // later, so a reset mid-transfer never leaks a half cycle to the slave.
  assign own0 = rst_ni && (state == OWN0);
  assign own1 = rst_ni && (state == OWN1);

  // The watchdog fires in the cycle after the strobe has been visible and
  // unterminated for TIMEOUT_CYCLES consecutive cycles.
  assign wd_fire = WD_ON && (own0 || own1) && (stall_cnt == TC_LIMIT);

  assign stalled = s_stb_o && !(s_ack_i || s_err_i || s_rty_i);

  // Route the owner's request to the slave; cyc/stb are cut while the
  // watchdog is terminating the cycle.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_sel_o = '0;
    s_dat_o = '0;
    if (own0) begin
      s_cyc_o = m0_cyc_i && !wd_fire;
      s_stb_o = m0_stb_i && !wd_fire;
      s_we_o  = m0_we_i;
      s_adr_o = m0_adr_i;
      s_sel_o = m0_sel_i;
      s_dat_o = m0_dat_i;
    end else if (own1) begin
      s_cyc_o = m1_cyc_i && !wd_fire;
      s_stb_o = m1_stb_i && !wd_fire;
      s_we_o  = m1_we_i;
      s_adr_o = m1_adr_i;
      s_sel_o = m1_sel_i;
      s_dat_o = m1_dat_i;
    end
  end

  // Route slave terminations to the owner only; a timeout shows up as err.
  always_comb begin
    m0_ack_o = own0 && s_ack_i;
    m0_err_o = own0 && (s_err_i || wd_fire);
    m0_rty_o = own0 && s_rty_i;
    m1_ack_o = own1 && s_ack_i;
    m1_err_o = own1 && (s_err_i || wd_fire);
    m1_rty_o = own1 && s_rty_i;
  end

  assign m0_dat_o      = s_dat_i;
  assign m1_dat_o      = s_dat_i;
  assign bus_timeout_o = wd_fire;
  assign grant_o       = grant_q & {2{rst_ni}};

  // Ownership FSM: round-robin tie break on last_owner, grant held until
  // the owner drops cyc, then one IDLE cycle before the next owner.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      grant_q    <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (m0_cyc_i && (!m1_cyc_i || last_owner)) begin
            state      <= OWN0;
            last_owner <= 1'b0;
            grant_q    <= 2'b01;
          end else if (m1_cyc_i) begin
            state      <= OWN1;
            last_owner <= 1'b1;
            grant_q    <= 2'b10;
          end
        end
        OWN0: begin
          if (!m0_cyc_i) begin
            state   <= IDLE;
            grant_q <= 2'b00;
          end
        end
        OWN1: begin
          if (!m1_cyc_i) begin
            state   <= IDLE;
            grant_q <= 2'b00;
          end
        end
        default: begin
          state   <= IDLE;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

  // Stall counter: counts consecutive unterminated strobe cycles. The fire
  // cycle drops stb, so the counter clears itself on the following edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_cnt <= '0;
    end else if (!WD_ON || (state == IDLE) || !stalled) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus a randomized run checked
// against a cycle-level ownership/watchdog model.

module tb_wb_arbiter;

  localparam int TO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  cyc, stb, we;
  logic [31:0] adr  [2];
  logic [31:0] wdat [2];
  logic [3:0]  sel  [2];
  logic [31:0] s_rdat;
  logic        s_ack, s_err, s_rty;

  logic [31:0] m0_dat, m1_dat;
  logic        m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_wdat;
  logic [3:0]  s_sel;
  logic [1:0]  grant;
  logic        bus_to;

  logic [31:0] n_m0_dat, n_m1_dat;
  logic        n_m0_ack, n_m0_err, n_m0_rty, n_m1_ack, n_m1_err, n_m1_rty;
  logic        n_s_cyc, n_s_stb, n_s_we;
  logic [31:0] n_s_adr, n_s_wdat;
  logic [3:0]  n_s_sel;
  logic [1:0]  n_grant;
  logic        n_bus_to;

  int n_checks = 0;
  int n_fail   = 0;

  wb_arbiter #(.TIMEOUT_CYCLES(TO)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_adr_i(adr[0]),
    .m0_sel_i(sel[0]), .m0_dat_i(wdat[0]), .m0_dat_o(m0_dat),
    .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_rty_o(m0_rty),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_adr_i(adr[1]),
    .m1_sel_i(sel[1]), .m1_dat_i(wdat[1]), .m1_dat_o(m1_dat),
    .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_rty_o(m1_rty),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr),
    .s_sel_o(s_sel), .s_dat_o(s_wdat), .s_dat_i(s_rdat),
    .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
    .grant_o(grant), .bus_timeout_o(bus_to)
  );

  wb_arbiter #(.TIMEOUT_CYCLES(0)) u_dut_nowd (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_adr_i(adr[0]),
    .m0_sel_i(sel[0]), .m0_dat_i(wdat[0]), .m0_dat_o(n_m0_dat),
    .m0_ack_o(n_m0_ack), .m0_err_o(n_m0_err), .m0_rty_o(n_m0_rty),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_adr_i(adr[1]),
    .m1_sel_i(sel[1]), .m1_dat_i(wdat[1]), .m1_dat_o(n_m1_dat),
    .m1_ack_o(n_m1_ack), .m1_err_o(n_m1_err), .m1_rty_o(n_m1_rty),
    .s_cyc_o(n_s_cyc), .s_stb_o(n_s_stb), .s_we_o(n_s_we), .s_adr_o(n_s_adr),
    .s_sel_o(n_s_sel), .s_dat_o(n_s_wdat), .s_dat_i(s_rdat),
    .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
    .grant_o(n_grant), .bus_timeout_o(n_bus_to)
  );

  // Reference model: owner (-1 = nobody), last owner, consecutive stall count.
  int mod_owner = -1;
  int mod_last  = 1;
  int mod_stall = 0;

  function automatic logic mod_fire();
    return (mod_owner >= 0) && (TO != 0) && (mod_stall == TO);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      mod_owner = -1;
      mod_last  = 1;
      mod_stall = 0;
    end else begin
      if (mod_owner < 0)
        mod_stall = 0;
      else if (!mod_fire() && stb[mod_owner] && !(s_ack || s_err || s_rty))
        mod_stall = mod_stall + 1;
      else
        mod_stall = 0;
      if (mod_owner < 0) begin
        if (cyc[0] && cyc[1]) mod_owner = 1 - mod_last;
        else if (cyc[0])      mod_owner = 0;
        else if (cyc[1])      mod_owner = 1;
        if (mod_owner >= 0) mod_last = mod_owner;
      end else if (!cyc[mod_owner]) begin
        mod_owner = -1;
      end
    end
  end

  task automatic clear_inputs();
    cyc = 2'b00; stb = 2'b00; we = 2'b00;
    for (int m = 0; m < 2; m++) begin
      adr[m] = '0; wdat[m] = '0; sel[m] = '0;
    end
    s_rdat = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    cyc = 2'b11; stb = 2'b11;
    adr[0] = 32'hA000_0010; adr[1] = 32'hB000_0020;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      n_checks++;
      if (s_cyc !== 1'b0) begin
        n_fail++; $display("FAIL reset_s_cyc: got %b expected 0", s_cyc);
      end
      n_checks++;
      if (grant !== 2'b00) begin
        n_fail++; $display("FAIL reset_grant: got %b expected 00", grant);
      end
    end
    rst_n = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if (grant !== 2'b01) begin
      n_fail++; $display("FAIL reset_first_grant: got %b expected 01", grant);
    end
    n_checks++;
    if (s_adr !== 32'hA000_0010 || s_cyc !== 1'b1) begin
      n_fail++; $display("FAIL reset_first_adr: got %h/%b expected a0000010/1", s_adr, s_cyc);
    end
  endtask

  task automatic test_alternate();
    logic [1:0] exp_g [8] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01};
    do_reset();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      case (k)
        0: begin cyc = 2'b11; stb = 2'b11; s_ack = 1'b1; end
        2: begin cyc[0] = 1'b0; stb[0] = 1'b0; s_ack = 1'b0; end
        3: begin cyc[0] = 1'b1; stb[0] = 1'b1; end
        4: s_ack = 1'b1;
        5: begin cyc[1] = 1'b0; stb[1] = 1'b0; s_ack = 1'b0; end
        6: begin cyc[1] = 1'b1; stb[1] = 1'b1; end
        7: s_ack = 1'b1;
        default: ;
      endcase
      #1;
      n_checks++;
      if (grant !== exp_g[k]) begin
        n_fail++; $display("FAIL alt_grant[%0d]: got %b expected %b", k, grant, exp_g[k]);
      end
      n_checks++;
      if (grant == 2'b01 && m1_ack !== 1'b0) begin
        n_fail++; $display("FAIL alt_m1_ack_leak[%0d]: got %b expected 0", k, m1_ack);
      end
      if (k == 1 || k == 4) begin
        n_checks++;
        if ({m0_ack, m1_ack} !== ((k == 1) ? 2'b10 : 2'b01)) begin
          n_fail++; $display("FAIL alt_ack_route[%0d]: got %b", k, {m0_ack, m1_ack});
        end
      end
    end
  endtask

  task automatic test_hold();
    int acks = 0;
    do_reset();
    @(negedge clk);
    cyc = 2'b11; stb = 2'b11; adr[1] = 32'h0000_5A5C;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      s_ack = (k % 2 == 1);
      #1;
      if (m0_ack === 1'b1) acks++;
      n_checks++;
      if (grant !== 2'b01 || m1_ack !== 1'b0) begin
        n_fail++; $display("FAIL hold_owner[%0d]: got %b/%b expected 01/0", k, grant, m1_ack);
      end
    end
    n_checks++;
    if (acks != 3) begin
      n_fail++; $display("FAIL hold_acks: got %0d expected 3", acks);
    end
    @(negedge clk);
    cyc[0] = 1'b0; stb[0] = 1'b0; s_ack = 1'b0;
    #1;
    n_checks++;
    if (grant !== 2'b01) begin
      n_fail++; $display("FAIL hold_drop0: got %b expected 01", grant);
    end
    @(negedge clk); #1;
    n_checks++;
    if (grant !== 2'b00) begin
      n_fail++; $display("FAIL hold_drop1: got %b expected 00", grant);
    end
    @(negedge clk); #1;
    n_checks++;
    if (grant !== 2'b10 || s_adr !== 32'h0000_5A5C) begin
      n_fail++; $display("FAIL hold_drop2: got %b/%h expected 10/00005a5c", grant, s_adr);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    @(negedge clk);
    cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 32'h1234_0000;
    #1;
    n_checks++;
    if (s_stb !== 1'b0) begin
      n_fail++; $display("FAIL to_idle_stb: got %b expected 0", s_stb);
    end
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk); #1;
      n_checks++;
      if (s_stb !== 1'b1 || bus_to !== 1'b0 || m0_err !== 1'b0) begin
        n_fail++; $display("FAIL to_stall[%0d]: got stb=%b to=%b err=%b expected 1/0/0", k, s_stb, bus_to, m0_err);
      end
    end
    @(negedge clk); #1;
    n_checks++;
    if ({m0_err, bus_to, s_cyc, s_stb, m1_err} !== 5'b11000) begin
      n_fail++; $display("FAIL to_fire: got %b expected 11000", {m0_err, bus_to, s_cyc, s_stb, m1_err});
    end
    n_checks++;
    if (n_bus_to !== 1'b0 || n_s_stb !== 1'b1 || n_m0_err !== 1'b0) begin
      n_fail++; $display("FAIL to_off: got to=%b stb=%b err=%b expected 0/1/0", n_bus_to, n_s_stb, n_m0_err);
    end
    @(negedge clk); #1;
    n_checks++;
    if (s_stb !== 1'b1 || bus_to !== 1'b0 || grant !== 2'b01) begin
      n_fail++; $display("FAIL to_after: got stb=%b to=%b g=%b expected 1/0/01", s_stb, bus_to, grant);
    end
  endtask

  task automatic test_terminations();
    logic [2:0] exp_t [3] = '{3'b010, 3'b001, 3'b110};
    do_reset();
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      {s_ack, s_err, s_rty} = exp_t[k];
      s_rdat = $urandom;
      #1;
      n_checks++;
      if ({m1_ack, m1_err, m1_rty} !== exp_t[k]) begin
        n_fail++; $display("FAIL term_m1[%0d]: got %b expected %b", k, {m1_ack, m1_err, m1_rty}, exp_t[k]);
      end
      n_checks++;
      if ({m0_ack, m0_err, m0_rty} !== 3'b000) begin
        n_fail++; $display("FAIL term_m0[%0d]: got %b expected 000", k, {m0_ack, m0_err, m0_rty});
      end
      n_checks++;
      if (m0_dat !== s_rdat || m1_dat !== s_rdat) begin
        n_fail++; $display("FAIL term_dat[%0d]: got %h/%h expected %h", k, m0_dat, m1_dat, s_rdat);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'hDEAD_0004;
    sel[1] = 4'hF; wdat[1] = 32'hCAFE_F00D;
    repeat (3) @(negedge clk);
    rst_n = 1'b0; cyc = 2'b11; stb = 2'b11; s_ack = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (k == 1) @(negedge clk);
      #1;
      n_checks++;
      if ({s_cyc, s_stb, s_we, s_adr, s_sel, s_wdat, grant, bus_to,
           m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty} !== '0) begin
        n_fail++; $display("FAIL rstmid_quiet[%0d]: got cyc=%b stb=%b adr=%h g=%b ack=%b%b", k, s_cyc, s_stb, s_adr, grant, m0_ack, m1_ack);
      end
    end
    rst_n = 1'b1; s_ack = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (grant !== 2'b01) begin
      n_fail++; $display("FAIL rstmid_grant: got %b expected 01", grant);
    end
    for (int k = 2; k <= TO + 1; k++) begin
      @(negedge clk); #1;
      n_checks++;
      if (bus_to !== (k == TO + 1)) begin
        n_fail++; $display("FAIL rstmid_wd[%0d]: got %b expected %b", k, bus_to, (k == TO + 1));
      end
    end
  endtask

  task automatic test_random();
    int          o;
    logic        f;
    logic [70:0] eb, ab;
    logic [5:0]  et, at;
    logic [1:0]  eg;
    int          r;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 99) != 0);
      for (int m = 0; m < 2; m++) begin
        if (cyc[m]) cyc[m] = ($urandom_range(0, 5) != 0);
        else        cyc[m] = ($urandom_range(0, 2) == 0);
        stb[m]  = cyc[m] && ($urandom_range(0, 3) != 0);
        we[m]   = $urandom_range(0, 1);
        adr[m]  = $urandom;
        wdat[m] = $urandom;
        sel[m]  = 4'($urandom);
      end
      s_rdat = $urandom;
      r = $urandom_range(0, 7);
      s_ack = (r <= 1) || (r == 4);
      s_err = (r == 2) || (r == 4);
      s_rty = (r == 3);
      #1;
      o = rst_n ? mod_owner : -1;
      f = (o >= 0) && mod_fire();
      eb = '0; et = '0; eg = 2'b00;
      if (o >= 0) begin
        eb = {f ? 1'b0 : cyc[o], f ? 1'b0 : stb[o], we[o], sel[o], adr[o], wdat[o]};
        eg = (o == 0) ? 2'b01 : 2'b10;
        if (o == 0) et[5:3] = {s_ack, s_err | f, s_rty};
        else        et[2:0] = {s_ack, s_err | f, s_rty};
      end
      ab = {s_cyc, s_stb, s_we, s_sel, s_adr, s_wdat};
      at = {m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty};
      n_checks++;
      if (grant !== eg) begin
        n_fail++; $display("FAIL rnd_grant[%0d]: got %b expected %b", i, grant, eg);
      end
      n_checks++;
      if (ab !== eb) begin
        n_fail++; $display("FAIL rnd_bus[%0d]: got %h expected %h", i, ab, eb);
      end
      n_checks++;
      if (at !== et) begin
        n_fail++; $display("FAIL rnd_term[%0d]: got %b expected %b", i, at, et);
      end
      n_checks++;
      if (bus_to !== f) begin
        n_fail++; $display("FAIL rnd_timeout[%0d]: got %b expected %b", i, bus_to, f);
      end
      n_checks++;
      if (m0_dat !== s_rdat || m1_dat !== s_rdat) begin
        n_fail++; $display("FAIL rnd_dat[%0d]: got %h/%h expected %h", i, m0_dat, m1_dat, s_rdat);
      end
      n_checks++;
      if (n_bus_to !== 1'b0 || n_grant !== eg) begin
        n_fail++; $display("FAIL rnd_nowd[%0d]: got to=%b g=%b expected 0/%b", i, n_bus_to, n_grant, eg);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_alternate();
    test_hold();
    test_timeout();
    test_terminations();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
